// File: rtl/nec_pkg.sv
// nec_pkg: shared NEC IR protocol definitions.
//   nec_state_t      transmitter/decoder state encoding
//   NEC_* localparams default timing at 50 MHz
//   is_mark()        1 for states that drive the LED (envelope low)
package nec_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    GAP
  } nec_state_t;

  localparam int NEC_CLKS_PER_UNIT      = 28125;
  localparam int NEC_CARRIER_DIV        = 1316;
  localparam int NEC_LEADER_MARK_UNITS  = 16;
  localparam int NEC_LEADER_SPACE_UNITS = 8;
  localparam int NEC_REPEAT_SPACE_UNITS = 4;
  localparam int NEC_FRAME_UNITS        = 192;

  function automatic logic is_mark(input nec_state_t s);
    return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
  endfunction

endpackage

// File: rtl/nec_carrier_gen.sv
// nec_carrier_gen: carrier divider for the IR LED drive.
//   clk      in  system clock
//   rst_n    in  synchronous active-low reset
//   en       in  1 when the coming cycle is a mark
//   carrier  out registered carrier, high for the first CARRIER_DIV/2 clocks of each period
// The divider restarts at 0 whenever en rises, so every mark begins high;
// it is held at 0 while en is low.
module nec_carrier_gen #(
  parameter int CARRIER_DIV = 1316
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic carrier
);

  localparam int CW = $clog2(CARRIER_DIV);
  localparam logic [CW-1:0] CARR_LAST = CW'(CARRIER_DIV - 1);
  localparam logic [CW-1:0] CARR_HALF = CW'(CARRIER_DIV / 2);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          en_q;

  // en_q says the current cycle is already a mark; otherwise this is the first one.
  always_comb begin
    cnt_nxt = '0;
    if (en && en_q) cnt_nxt = (cnt == CARR_LAST) ? '0 : cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      en_q    <= 1'b0;
      carrier <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      en_q    <= en;
      carrier <= en && (cnt_nxt < CARR_HALF);
    end
  end

endmodule

// File: rtl/nec_ir_tx.sv
// nec_ir_tx: NEC protocol IR transmitter.
//   clk           in  system clock
//   rst_n         in  synchronous active-low reset
//   valid         in  request strobe, accepted when valid & ready
//   repeat_req    in  1 = send repeat code (data_to_send ignored)
//   data_to_send  in  32-bit frame, bit 0 sent first
//   ready         out 1 only in IDLE
//   busy          out ~ready
//   ir_tx         out carrier-modulated LED drive
//   ir_env_n      out active-low envelope (0 during marks)
module nec_ir_tx
  import nec_pkg::*;
#(
  parameter int CLKS_PER_UNIT      = NEC_CLKS_PER_UNIT,
  parameter int CARRIER_DIV        = NEC_CARRIER_DIV,
  parameter int LEADER_MARK_UNITS  = NEC_LEADER_MARK_UNITS,
  parameter int LEADER_SPACE_UNITS = NEC_LEADER_SPACE_UNITS,
  parameter int REPEAT_SPACE_UNITS = NEC_REPEAT_SPACE_UNITS,
  parameter int FRAME_UNITS        = NEC_FRAME_UNITS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic        repeat_req,
  input  logic [31:0] data_to_send,
  output logic        ready,
  output logic        busy,
  output logic        ir_tx,
  output logic        ir_env_n
);

  localparam int UW = $clog2(CLKS_PER_UNIT);
  localparam int SW = $clog2(LEADER_MARK_UNITS);
  localparam int FW = $clog2(FRAME_UNITS);
  localparam logic [UW-1:0] UNIT_LAST  = UW'(CLKS_PER_UNIT - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_UNITS - 1);

  nec_state_t    state;
  logic [UW-1:0] unit_cnt;
  logic [SW-1:0] state_units;
  logic [SW-1:0] dur_last;
  logic [FW-1:0] frame_cnt;
  logic [4:0]    bit_idx;
  logic [31:0]   data;
  logic          rpt;
  logic          accept;
  logic          tick;
  logic          leave;
  logic          mark_nxt;

  assign accept = valid && ready;
  assign tick   = (unit_cnt == UNIT_LAST);

  // Last unit index of the current state.
  always_comb begin
    dur_last = '0;
    case (state)
      LEAD_MARK:  dur_last = SW'(LEADER_MARK_UNITS - 1);
      LEAD_SPACE: dur_last = rpt ? SW'(REPEAT_SPACE_UNITS - 1) : SW'(LEADER_SPACE_UNITS - 1);
      BIT_SPACE:  dur_last = data[bit_idx] ? SW'(2) : '0;
      default:    dur_last = '0;
    endcase
  end

  // GAP ends on the frame boundary, every other state on its own length.
  always_comb begin
    leave = 1'b0;
    if (state == GAP)       leave = tick && (frame_cnt == FRAME_LAST);
    else if (state != IDLE) leave = tick && (state_units == dur_last);
  end

  // Marks and spaces strictly alternate, except GAP -> IDLE (space to space).
  always_comb begin
    if (state == IDLE) mark_nxt = accept;
    else if (leave)    mark_nxt = !is_mark(state) && (state != GAP);
    else               mark_nxt = is_mark(state);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ready       <= 1'b1;
      busy        <= 1'b0;
      ir_env_n    <= 1'b1;
      unit_cnt    <= '0;
      state_units <= '0;
      frame_cnt   <= '0;
      bit_idx     <= '0;
      data        <= '0;
      rpt         <= 1'b0;
    end else begin
      ir_env_n <= !mark_nxt;
      if (state == IDLE) begin
        if (accept) begin
          data        <= data_to_send;
          rpt         <= repeat_req;
          state       <= LEAD_MARK;
          ready       <= 1'b0;
          busy        <= 1'b1;
          unit_cnt    <= '0;
          state_units <= '0;
          frame_cnt   <= '0;
          bit_idx     <= '0;
        end
      end else begin
        unit_cnt <= tick ? '0 : unit_cnt + 1'b1;
        if (tick && (frame_cnt != FRAME_LAST)) frame_cnt <= frame_cnt + 1'b1;
        if (leave) begin
          state_units <= '0;
          case (state)
            LEAD_MARK:  state <= LEAD_SPACE;
            LEAD_SPACE: begin
              state   <= rpt ? STOP_MARK : BIT_MARK;
              bit_idx <= '0;
            end
            BIT_MARK:   state <= BIT_SPACE;
            BIT_SPACE: begin
              if (bit_idx == 5'd31) begin
                state <= STOP_MARK;
              end else begin
                state   <= BIT_MARK;
                bit_idx <= bit_idx + 1'b1;
              end
            end
            STOP_MARK:  state <= GAP;
            default: begin
              state <= IDLE;
              ready <= 1'b1;
              busy  <= 1'b0;
            end
          endcase
        end else if (tick && (state != GAP)) begin
          state_units <= state_units + 1'b1;
        end
      end
    end
  end

  nec_carrier_gen #(
    .CARRIER_DIV(CARRIER_DIV)
  ) u_carrier (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (mark_nxt),
    .carrier(ir_tx)
  );

endmodule

// File: tb/tb_nec_ir_tx.sv
// tb_nec_ir_tx: bench for nec_ir_tx with short sim timing.
// Expected waveforms come from a segment list (mark/space, length in units)
// built from the NEC frame rules and expanded to one value per clock.
module tb_nec_ir_tx;

  localparam int CPU = 8;
  localparam int CD  = 4;
  localparam int FU  = 192;
  localparam int FC  = FU * CPU;

  typedef struct {
    bit mark;
    int units;
  } seg_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        repeat_req = 1'b0;
  logic [31:0] data_to_send = '0;
  logic        ready;
  logic        busy;
  logic        ir_tx;
  logic        ir_env_n;

  int n_cmp  = 0;
  int n_fail = 0;
  bit exp_env [FC];
  bit exp_tx  [FC];
  int space_start [32];

  always #5 clk = ~clk;

  nec_ir_tx #(
    .CLKS_PER_UNIT     (CPU),
    .CARRIER_DIV       (CD),
    .LEADER_MARK_UNITS (16),
    .LEADER_SPACE_UNITS(8),
    .REPEAT_SPACE_UNITS(4),
    .FRAME_UNITS       (FU)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid       (valid),
    .repeat_req  (repeat_req),
    .data_to_send(data_to_send),
    .ready       (ready),
    .busy        (busy),
    .ir_tx       (ir_tx),
    .ir_env_n    (ir_env_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_env"}, ir_env_n, 1);
    chk({tag, "_tx"}, ir_tx, 0);
  endtask

  // Reference: per-clock envelope and carrier for one frame, index 0 = first cycle after accept.
  task automatic build_model(input logic [31:0] d, input bit r);
    seg_t q[$];
    int   idx = 0;
    q.push_back('{1'b1, 16});
    q.push_back('{1'b0, r ? 4 : 8});
    if (!r) begin
      for (int b = 0; b < 32; b++) begin
        q.push_back('{1'b1, 1});
        q.push_back('{1'b0, d[b] ? 3 : 1});
      end
    end
    q.push_back('{1'b1, 1});
    for (int i = 0; i < FC; i++) begin
      exp_env[i] = 1'b1;
      exp_tx[i]  = 1'b0;
    end
    for (int b = 0; b < 32; b++) space_start[b] = -1;
    for (int s = 0; s < q.size(); s++) begin
      if (!r && s >= 3 && s <= 65 && (s % 2 == 1)) space_start[(s - 3) / 2] = idx;
      for (int c = 0; c < q[s].units * CPU; c++) begin
        exp_env[idx] = !q[s].mark;
        exp_tx[idx]  = q[s].mark && ((c % CD) < (CD / 2));
        idx++;
      end
    end
  endtask

  // Called at a negedge with the DUT idle. abort_bit >= 0 pulses reset two
  // clocks into that bit's space and returns after checking the idle state.
  task automatic run_frame(input logic [31:0] d, input bit r, input bit hold,
                           input bit chg, input int abort_bit);
    int abort_at;
    build_model(d, r);
    abort_at = (abort_bit >= 0) ? space_start[abort_bit] + 2 : -1;
    data_to_send = d;
    repeat_req   = r;
    valid        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) valid = 1'b0;
    for (int i = 0; i < FC; i++) begin
      if (i == abort_at) begin
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk_idle($sformatf("abort@%0d", i));
        return;
      end
      chk($sformatf("env@%0d", i), ir_env_n, exp_env[i]);
      chk($sformatf("tx@%0d", i), ir_tx, exp_tx[i]);
      chk($sformatf("ready@%0d", i), ready, 0);
      chk($sformatf("busy@%0d", i), busy, 1);
      if (chg && i == 100) begin
        data_to_send = $urandom;
        repeat_req   = ~r;
      end
      @(negedge clk);
    end
    chk_idle("frame_end");
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("after_reset");

    run_frame(32'hFD02_FF00, 1'b0, 1'b0, 1'b0, -1);
    run_frame($urandom, 1'b1, 1'b0, 1'b0, -1);
    run_frame($urandom, 1'b0, 1'b1, 1'b1, -1);
    run_frame($urandom, 1'b0, 1'b0, 1'b0, -1);
    run_frame($urandom, 1'b0, 1'b0, 1'b0, 10);
    run_frame($urandom, 1'b0, 1'b0, 1'b0, -1);
    run_frame($urandom, 1'b1, 1'b1, 1'b0, -1);
    run_frame(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, -1);
    run_frame($urandom, 1'b0, 1'b0, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
